// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end: key identifiers,
// the fixed arbitration order and raw button levels.
package key_pkg;

   typedef enum logic [1:0] {
      KEY_SET = 2'd0,
      KEY_SEL = 2'd1,
      KEY_INC = 2'd2
   } key_id_t;

   localparam int NUM_KEYS = 3;

   // Arbitration order, highest priority first.
   localparam key_id_t KEY_PRIO [NUM_KEYS] = '{KEY_SET, KEY_SEL, KEY_INC};

   // Buttons pull low when pressed.
   localparam logic KEY_PRESSED  = 1'b0;
   localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, stable-level debouncer and a registered
// single-cycle press event on the released->pressed transition of the
// debounced level.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic pressed_o,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             db_q, db_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Bring the asynchronous pin into the clk domain; resets to released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= KEY_RELEASED;
         sync2_q <= KEY_RELEASED;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive samples that disagree with the debounced level; any
   // agreeing sample restarts the count. The level is accepted on the sample
   // that finds the count already at DEB_CYCLES.
   always_comb begin
      db_d    = db_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES)) begin
         db_d    = sync2_q;
         cnt_d   = '0;
         press_d = (sync2_q == KEY_PRESSED);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounced level, stability counter and press event registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_q    <= KEY_RELEASED;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign pressed_o = (db_q == KEY_PRESSED);
   assign press_o   = press_q;

endmodule

// File: rtl/key_sequencer.sv
// Push-button front end for the time-setting FSM: three debounced keys,
// pending-event flags and a fixed-priority (SET > SEL > INC) arbiter that
// issues at most one registered command pulse per cycle.
// Optional INC auto-repeat while setting mode is active is built when
// KEY_AUTOREPEAT_EN is defined; otherwise INC fires only on presses and the
// repeat parameters are ignored.
module key_sequencer
#(
   parameter int DEB_CYCLES = 50000,
   parameter int REP_START  = 25000000,
   parameter int REP_PERIOD = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_set_n,
   input  logic key_sel_n,
   input  logic key_inc_n,
   input  logic set_en,
   output logic set_p,
   output logic sel_p,
   output logic inc_p,
   output logic key_active
);

   import key_pkg::*;

   logic [NUM_KEYS-1:0] held;
   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] event_v;
   logic [NUM_KEYS-1:0] grant;
   logic [NUM_KEYS-1:0] pend_q, pend_d;
   logic [NUM_KEYS-1:0] pulse_q;
   logic                rep_fire;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (key_set_n),
      .pressed_o (held[KEY_SET]),
      .press_o   (press[KEY_SET])
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (key_sel_n),
      .pressed_o (held[KEY_SEL]),
      .press_o   (press[KEY_SEL])
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (key_inc_n),
      .pressed_o (held[KEY_INC]),
      .press_o   (press[KEY_INC])
   );

`ifdef KEY_AUTOREPEAT_EN
   localparam int REP_MAX = (REP_START > REP_PERIOD) ? REP_START : REP_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_first_q, rep_first_d;

   // Repeat timer: restarts on every INC press and whenever INC is released
   // or setting mode is off; first interval REP_START, then REP_PERIOD.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_fire    = 1'b0;
      if (press[KEY_INC] || !held[KEY_INC] || !set_en) begin
         rep_cnt_d   = '0;
         rep_first_d = 1'b1;
      end else if (rep_cnt_q == (rep_first_q ? REP_W'(REP_START - 1)
                                             : REP_W'(REP_PERIOD - 1))) begin
         rep_fire    = 1'b1;
         rep_cnt_d   = '0;
         rep_first_d = 1'b0;
      end else begin
         rep_cnt_d = rep_cnt_q + 1'b1;
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`else
   localparam int unused_rep_cfg = REP_START + REP_PERIOD;
   logic unused_set_en;

   assign unused_set_en = set_en;
   assign rep_fire      = 1'b0;
`endif

   assign event_v[KEY_SET] = press[KEY_SET];
   assign event_v[KEY_SEL] = press[KEY_SEL];
   assign event_v[KEY_INC] = press[KEY_INC] | rep_fire;

   // Fixed-priority pick of the highest pending key.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (grant == '0 && pend_q[KEY_PRIO[i]]) begin
            grant[KEY_PRIO[i]] = 1'b1;
         end
      end
   end

   // Pending flags: issued flag clears, SET flushes SEL/INC (stale across a
   // mode change), new events merge into whatever is already pending.
   always_comb begin
      pend_d = pend_q & ~grant;
      if (grant[KEY_SET]) begin
         pend_d[KEY_SEL] = 1'b0;
         pend_d[KEY_INC] = 1'b0;
      end
      pend_d = pend_d | event_v;
   end

   // Pending flags and registered command pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         pulse_q <= '0;
      end else begin
         pend_q  <= pend_d;
         pulse_q <= grant;
      end
   end

   assign set_p      = pulse_q[KEY_SET];
   assign sel_p      = pulse_q[KEY_SEL];
   assign inc_p      = pulse_q[KEY_INC];
   assign key_active = |held;

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer with DEB_CYCLES=4, REP_START=20,
// REP_PERIOD=8. Expected pulses (key, cycle) are queued when keys are
// driven; a negedge monitor pops and compares every pulse it sees.
module tb_key_sequencer;

   typedef struct packed {
      logic [2:0] key;   // {inc, sel, set}
      int         at;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic key_set_n, key_sel_n, key_inc_n, set_en;
   logic set_p, sel_p, inc_p, key_active;

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   int   base;
   exp_t exp_q[$];

   key_sequencer #(
      .DEB_CYCLES (4),
      .REP_START  (20),
      .REP_PERIOD (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_set_n  (key_set_n),
      .key_sel_n  (key_sel_n),
      .key_inc_n  (key_inc_n),
      .set_en     (set_en),
      .set_p      (set_p),
      .sel_p      (sel_p),
      .inc_p      (inc_p),
      .key_active (key_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_pulse(input logic [2:0] key, input int at);
      exp_t e;
      e.key = key;
      e.at  = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Every observed pulse must match the next queued expectation.
   always @(negedge clk) begin : monitor
      logic [2:0] p;
      exp_t       e;
      p = {inc_p, sel_p, set_p};
      if (p !== 3'b000) begin
         e.key = 3'b000;
         e.at  = cyc;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         chk("pulse_key", {29'd0, p}, {29'd0, e.key});
         chk("pulse_cyc", cyc, e.at);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      key_set_n = 1'b1;
      key_sel_n = 1'b1;
      key_inc_n = 1'b1;
      set_en    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_set_p", set_p, 0);
      chk("rst_sel_p", sel_p, 0);
      chk("rst_inc_p", inc_p, 0);
      chk("rst_key_active", key_active, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Clean SEL press, held, then released.
      key_sel_n = 1'b0;
      base = cyc;
      expect_pulse(3'b010, base + 9);
      wait_to(base + 6);
      chk("sel_active_pre", key_active, 0);
      wait_to(base + 7);
      chk("sel_active_on", key_active, 1);
      wait_to(base + 30);
      key_sel_n = 1'b1;
      base = cyc;
      wait_to(base + 6);
      chk("sel_active_hold", key_active, 1);
      wait_to(base + 7);
      chk("sel_active_off", key_active, 0);
      wait_to(base + 15);
      chk("sel_missing", exp_q.size(), 0);

      // INC bounce: 3 low, 1 high, five times.
      for (int r = 0; r < 5; r++) begin
         key_inc_n = 1'b0;
         repeat (3) @(negedge clk);
         key_inc_n = 1'b1;
         @(negedge clk);
         chk("bounce_active", key_active, 0);
      end
      repeat (15) @(negedge clk);
      chk("bounce_active_end", key_active, 0);
      chk("bounce_missing", exp_q.size(), 0);

      // All three together: only SET survives.
      key_set_n = 1'b0;
      key_sel_n = 1'b0;
      key_inc_n = 1'b0;
      base = cyc;
      expect_pulse(3'b001, base + 9);
      wait_to(base + 20);
      key_set_n = 1'b1;
      key_sel_n = 1'b1;
      key_inc_n = 1'b1;
      wait_to(base + 40);
      chk("all3_missing", exp_q.size(), 0);

      // SEL and INC together: SEL then INC back-to-back.
      key_sel_n = 1'b0;
      key_inc_n = 1'b0;
      base = cyc;
      expect_pulse(3'b010, base + 9);
      expect_pulse(3'b100, base + 10);
      wait_to(base + 20);
      key_sel_n = 1'b1;
      key_inc_n = 1'b1;
      wait_to(base + 40);
      chk("selinc_missing", exp_q.size(), 0);

      // INC held 50 cycles in setting mode.
      set_en    = 1'b1;
      key_inc_n = 1'b0;
      base = cyc;
      expect_pulse(3'b100, base + 9);
`ifdef KEY_AUTOREPEAT_EN
      expect_pulse(3'b100, base + 29);
      expect_pulse(3'b100, base + 37);
      expect_pulse(3'b100, base + 45);
      expect_pulse(3'b100, base + 53);
`endif
      wait_to(base + 50);
      key_inc_n = 1'b1;
      wait_to(base + 75);
      set_en = 1'b0;
      chk("rep_on_missing", exp_q.size(), 0);

      // Same hold with setting mode off: single pulse.
      key_inc_n = 1'b0;
      base = cyc;
      expect_pulse(3'b100, base + 9);
      wait_to(base + 50);
      key_inc_n = 1'b1;
      wait_to(base + 75);
      chk("rep_off_missing", exp_q.size(), 0);

      // Reset while SEL is pending, key kept held through reset.
      key_sel_n = 1'b0;
      base = cyc;
      wait_to(base + 8);
      rst_n = 1'b0;
      #1;
      chk("midrst_sel_p", sel_p, 0);
      chk("midrst_key_active", key_active, 0);
      repeat (3) @(negedge clk);
      chk("midrst_sel_p_hold", sel_p, 0);
      rst_n = 1'b1;
      base = cyc;
      expect_pulse(3'b010, base + 9);
      wait_to(base + 6);
      chk("post_rst_active_pre", key_active, 0);
      wait_to(base + 7);
      chk("post_rst_active_on", key_active, 1);
      wait_to(base + 15);
      key_sel_n = 1'b1;
      wait_to(base + 35);
      chk("post_rst_missing", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
